// File: rtl/spike_sram_ctrl_if.sv
// Request/grant, readback and SRAM-pin bundle for spike_sram_ctrl.
// master = requesters plus SRAM macro side, slave = the controller.
interface spike_sram_ctrl_if #(
    parameter int ADDR_W    = 10,
    parameter int BIT_WIDTH = 1
);
    logic                 wr_req;
    logic [ADDR_W-1:0]    wr_addr;
    logic [BIT_WIDTH-1:0] wr_data;
    logic                 wr_gnt;

    logic                 clr_start;
    logic                 clr_busy;
    logic                 clr_done;

    logic                 ra_req;
    logic                 rb_req;
    logic [ADDR_W-1:0]    ra_addr;
    logic [ADDR_W-1:0]    rb_addr;
    logic                 ra_gnt;
    logic                 rb_gnt;
    logic                 rd_vld;
    logic                 rd_id;
    logic [BIT_WIDTH-1:0] rd_data;

    logic                 sram_csb;
    logic                 sram_wsb;
    logic [ADDR_W-1:0]    sram_waddr;
    logic [ADDR_W-1:0]    sram_raddr;
    logic [BIT_WIDTH-1:0] sram_wdata;
    logic [BIT_WIDTH-1:0] sram_rdata;

    modport master (
        output wr_req, wr_addr, wr_data, clr_start,
        output ra_req, rb_req, ra_addr, rb_addr, sram_rdata,
        input  wr_gnt, clr_busy, clr_done, ra_gnt, rb_gnt,
        input  rd_vld, rd_id, rd_data,
        input  sram_csb, sram_wsb, sram_waddr, sram_raddr, sram_wdata
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, clr_start,
        input  ra_req, rb_req, ra_addr, rb_addr, sram_rdata,
        output wr_gnt, clr_busy, clr_done, ra_gnt, rb_gnt,
        output rd_vld, rd_id, rd_data,
        output sram_csb, sram_wsb, sram_waddr, sram_raddr, sram_wdata
    );
endinterface

// File: rtl/spike_sram_ctrl.sv
// Write/clear and round-robin read sequencer in front of one spike SRAM.
// Define SPIKE_SRAM_RAW_FWD_EN to return fresh data on a same-cycle read/write collision.
module spike_sram_ctrl #(
    parameter int WORD_NUM  = 350,
    parameter int BIT_WIDTH = 1,
    parameter int ADDR_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    spike_sram_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0]   WORD_LIM  = WORD_NUM[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_NUM - 1);

    typedef enum logic [1:0] {CLR_IDLE, CLR_RUN, CLR_DONE} clr_state_e;

    clr_state_e           clrState_q, clrState_d;
    logic [ADDR_W-1:0]    clrCnt_q, clrCnt_d;
    logic                 clrWr, clrBusy, clrDone;

    logic                 wrGnt, raGnt, rbGnt, rdGnt;
    logic                 wrInRange, rdInRange, doWr;
    logic [ADDR_W-1:0]    rdAddr, wAddr;
    logic [BIT_WIDTH-1:0] wData, rdSrc;

    logic                 csb_q, wsb_q;
    logic [ADDR_W-1:0]    waddr_q, raddr_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic                 rrPtr_q;
    logic                 rdVld1_q, rdId1_q, rdOor1_q;
    logic                 rdVld_q, rdId_q;
    logic [BIT_WIDTH-1:0] rdData_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clrState_q <= CLR_IDLE;
            clrCnt_q   <= '0;
        end else begin
            clrState_q <= clrState_d;
            clrCnt_q   <= clrCnt_d;
        end
    end

    always_comb begin
        clrState_d = clrState_q;
        clrCnt_d   = clrCnt_q;
        clrWr      = 1'b0;
        clrBusy    = 1'b0;
        clrDone    = 1'b0;
        case (clrState_q)
            CLR_IDLE: begin
                if (bus.clr_start) begin
                    clrState_d = CLR_RUN;
                    clrCnt_d   = '0;
                end
            end
            CLR_RUN: begin
                clrBusy = 1'b1;
                clrWr   = 1'b1;
                if (clrCnt_q == LAST_ADDR) clrState_d = CLR_DONE;
                else                       clrCnt_d   = clrCnt_q + ADDR_W'(1);
            end
            CLR_DONE: begin
                clrDone    = 1'b1;
                clrState_d = CLR_IDLE;
            end
            default: clrState_d = CLR_IDLE;
        endcase
    end

    // Out-of-range requests are still granted; they just never enable the macro.
    always_comb begin
        wrGnt     = bus.wr_req & ~clrBusy;
        raGnt     = bus.ra_req & (~bus.rb_req | ~rrPtr_q);
        rbGnt     = bus.rb_req & (~bus.ra_req | rrPtr_q);
        rdGnt     = raGnt | rbGnt;
        rdAddr    = raGnt ? bus.ra_addr : bus.rb_addr;
        wrInRange = wrGnt & ({1'b0, bus.wr_addr} < WORD_LIM);
        rdInRange = rdGnt & ({1'b0, rdAddr} < WORD_LIM);
        doWr      = clrWr | wrInRange;
        wAddr     = clrWr ? clrCnt_q : bus.wr_addr;
        wData     = clrWr ? '0 : bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_q    <= 1'b1;
            wsb_q    <= 1'b1;
            waddr_q  <= '0;
            raddr_q  <= '0;
            wdata_q  <= '0;
            rrPtr_q  <= 1'b0;
            rdVld1_q <= 1'b0;
            rdId1_q  <= 1'b0;
            rdOor1_q <= 1'b0;
            rdVld_q  <= 1'b0;
            rdId_q   <= 1'b0;
            rdData_q <= '0;
        end else begin
            csb_q <= ~(doWr | rdInRange);
            wsb_q <= ~doWr;
            if (doWr) begin
                waddr_q <= wAddr;
                wdata_q <= wData;
            end
            if (rdInRange) raddr_q <= rdAddr;
            if (raGnt)      rrPtr_q <= 1'b1;
            else if (rbGnt) rrPtr_q <= 1'b0;
            rdVld1_q <= rdGnt;
            rdId1_q  <= rbGnt;
            rdOor1_q <= ~rdInRange;
            rdVld_q  <= rdVld1_q;
            rdId_q   <= rdId1_q;
            if (rdVld1_q) rdData_q <= rdOor1_q ? '0 : rdSrc;
        end
    end

`ifdef SPIKE_SRAM_RAW_FWD_EN
    logic                 fwdHit_q;
    logic [BIT_WIDTH-1:0] fwdData_q;

    // Remember a colliding write so its data can replace the stale macro output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwdHit_q  <= 1'b0;
            fwdData_q <= '0;
        end else begin
            fwdHit_q  <= rdInRange & doWr & (wAddr == rdAddr);
            fwdData_q <= wData;
        end
    end

    assign rdSrc = fwdHit_q ? fwdData_q : bus.sram_rdata;
`else
    assign rdSrc = bus.sram_rdata;
`endif

    assign bus.wr_gnt     = wrGnt;
    assign bus.ra_gnt     = raGnt;
    assign bus.rb_gnt     = rbGnt;
    assign bus.clr_busy   = clrBusy;
    assign bus.clr_done   = clrDone;
    assign bus.rd_vld     = rdVld_q;
    assign bus.rd_id      = rdId_q;
    assign bus.rd_data    = rdData_q;
    assign bus.sram_csb   = csb_q;
    assign bus.sram_wsb   = wsb_q;
    assign bus.sram_waddr = waddr_q;
    assign bus.sram_raddr = raddr_q;
    assign bus.sram_wdata = wdata_q;
endmodule

// File: tb/tb_spike_sram_ctrl.sv
// Scoreboard bench for spike_sram_ctrl with a behavioural SRAM (write on edge, read from registered address).
module tb_spike_sram_ctrl;
    localparam int WORD_NUM  = 350;
    localparam int BIT_WIDTH = 1;
    localparam int ADDR_W    = 10;

    typedef struct {
        int                   due;
        logic                 id;
        logic [BIT_WIDTH-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;

    exp_t                 sbQ[$];
    exp_t                 monE;
    logic [BIT_WIDTH-1:0] refMem [0:WORD_NUM-1];
    logic                 refPtr;
    logic [BIT_WIDTH-1:0] sramMem [0:1023];

    spike_sram_ctrl_if #(.ADDR_W(ADDR_W), .BIT_WIDTH(BIT_WIDTH)) bus ();

    spike_sram_ctrl #(
        .WORD_NUM (WORD_NUM),
        .BIT_WIDTH(BIT_WIDTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Macro model: the controller registers the address, the macro is read out from it combinationally.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) sramMem[i] <= '0;
        end else if (!bus.sram_csb && !bus.sram_wsb) begin
            sramMem[bus.sram_waddr] <= bus.sram_wdata;
        end
    end

    assign bus.sram_rdata = bus.sram_csb ? '0 : sramMem[bus.sram_raddr];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle of requests; grants are predicted from the bench's own pointer and memory model.
    task automatic applyStimulus(input bit wr, input int wa, input bit wd,
                                 input bit ra, input int raA, input bit rb, input int rbA,
                                 input string tag);
        bit   expRa, expRb;
        int   addr;
        exp_t e;
        bus.wr_req  = wr;
        bus.wr_addr = ADDR_W'(wa);
        bus.wr_data = wd;
        bus.ra_req  = ra;
        bus.ra_addr = ADDR_W'(raA);
        bus.rb_req  = rb;
        bus.rb_addr = ADDR_W'(rbA);
        @(negedge clk);
        if (ra && rb) begin
            expRa = !refPtr;
            expRb = refPtr;
        end else begin
            expRa = ra;
            expRb = rb;
        end
        checkOutput({tag, "_wr_gnt"}, 32'(bus.wr_gnt), 32'(wr));
        checkOutput({tag, "_ra_gnt"}, 32'(bus.ra_gnt), 32'(expRa));
        checkOutput({tag, "_rb_gnt"}, 32'(bus.rb_gnt), 32'(expRb));
        if (expRa || expRb) begin
            addr   = expRa ? raA : rbA;
            e.due  = cyc + 2;
            e.id   = expRb;
            e.data = (addr < WORD_NUM) ? refMem[addr] : '0;
`ifdef SPIKE_SRAM_RAW_FWD_EN
            if (wr && wa == addr && addr < WORD_NUM) e.data = wd;
`endif
            sbQ.push_back(e);
            refPtr = expRa;
        end
        if (wr && wa < WORD_NUM) refMem[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rd_vld) begin
            if (sbQ.size() == 0) begin
                checkOutput("rd_unexpected", 32'(bus.rd_vld), 32'(0));
            end else begin
                monE = sbQ.pop_front();
                checkOutput("rd_cycle", 32'(cyc), 32'(monE.due));
                checkOutput("rd_id", 32'(bus.rd_id), 32'(monE.id));
                checkOutput("rd_data", 32'(bus.rd_data), 32'(monE.data));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int zeroCnt, doneCnt;
        bit gotGnt, doneAtGnt;

        rst = 1'b1;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clr_start = 1'b0;
        bus.ra_req = 1'b0; bus.ra_addr = '0;
        bus.rb_req = 1'b0; bus.rb_addr = '0;
        for (int i = 0; i < WORD_NUM; i++) refMem[i] = '0;
        refPtr = 1'b0;

        $display("[TB] reset values");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_csb", 32'(bus.sram_csb), 32'(1));
        checkOutput("rst_wsb", 32'(bus.sram_wsb), 32'(1));
        checkOutput("rst_waddr", 32'(bus.sram_waddr), 32'(0));
        checkOutput("rst_raddr", 32'(bus.sram_raddr), 32'(0));
        checkOutput("rst_wdata", 32'(bus.sram_wdata), 32'(0));
        checkOutput("rst_rd_vld", 32'(bus.rd_vld), 32'(0));
        checkOutput("rst_rd_id", 32'(bus.rd_id), 32'(0));
        checkOutput("rst_rd_data", 32'(bus.rd_data), 32'(0));
        checkOutput("rst_clr_busy", 32'(bus.clr_busy), 32'(0));
        checkOutput("rst_clr_done", 32'(bus.clr_done), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] reset during clear");
        bus.clr_start = 1'b1;
        @(negedge clk);
        checkOutput("clr_busy_pre", 32'(bus.clr_busy), 32'(0));
        @(posedge clk);
        #1 bus.clr_start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        checkOutput("clr_busy_mid", 32'(bus.clr_busy), 32'(1));
        checkOutput("clr_wsb_mid", 32'(bus.sram_wsb), 32'(0));
        checkOutput("clr_waddr_mid", 32'(bus.sram_waddr), 32'(99));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(bus.clr_busy), 32'(0));
        checkOutput("abort_done", 32'(bus.clr_done), 32'(0));
        checkOutput("abort_csb", 32'(bus.sram_csb), 32'(1));
        checkOutput("abort_wsb", 32'(bus.sram_wsb), 32'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", 32'(bus.clr_done), 32'(0));
        end
        @(posedge clk);
        #1;

        $display("[TB] write then read");
        applyStimulus(1, 5, 1, 0, 0, 0, 0, "wr5");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "idle");
        applyStimulus(0, 0, 0, 1, 5, 0, 0, "rdA5");
        applyStimulus(0, 0, 0, 0, 0, 1, 6, "rdB6");

        $display("[TB] round robin");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 5, 1, 6, "rr");
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, "idle");

        $display("[TB] fill, clear, readback");
        for (int a = 0; a < WORD_NUM; a++)
            applyStimulus(1, a, 1, 0, 0, (a > 0), (a > 0) ? a - 1 : 0, "fill");
        bus.rb_req = 1'b0;
        bus.wr_req = 1'b0;
        bus.clr_start = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_start = 1'b0;
        bus.wr_req = 1'b1; bus.wr_addr = ADDR_W'(7); bus.wr_data = 1'b1;
        zeroCnt = 0; doneCnt = 0; gotGnt = 1'b0; doneAtGnt = 1'b0;
        for (int i = 0; i < 400 && !gotGnt; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("clr_busy_run", 32'(bus.clr_busy), 32'(1));
            if (bus.clr_done) doneCnt++;
            if (bus.wr_gnt) begin
                gotGnt = 1'b1;
                doneAtGnt = bus.clr_done;
            end else begin
                zeroCnt++;
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < WORD_NUM; i++) refMem[i] = '0;
        refMem[7] = 1'b1;
        @(posedge clk);
        #1 bus.wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.clr_done) doneCnt++;
        end
        @(posedge clk);
        #1;
        checkOutput("wr_gnt_seen", 32'(gotGnt), 32'(1));
        checkOutput("wr_stall_cycles", 32'(zeroCnt), 32'(WORD_NUM));
        checkOutput("clr_done_at_gnt", 32'(doneAtGnt), 32'(1));
        checkOutput("clr_done_pulses", 32'(doneCnt), 32'(1));
        for (int a = 0; a < WORD_NUM; a++)
            applyStimulus(0, 0, 0, (a % 2 == 0), a, (a % 2 == 1), a, "readback");
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, "idle");

        $display("[TB] same-cycle read/write");
        applyStimulus(1, 20, 1, 1, 20, 0, 0, "raw20");
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, "idle");

        $display("[TB] address boundaries");
        applyStimulus(1, WORD_NUM - 1, 1, 0, 0, 0, 0, "wr_last");
        applyStimulus(1, WORD_NUM, 1, 0, 0, 0, 0, "wr_oor");
        checkOutput("wr_oor_wsb", 32'(bus.sram_wsb), 32'(1));
        checkOutput("wr_oor_csb", 32'(bus.sram_csb), 32'(1));
        applyStimulus(0, 0, 0, 1, WORD_NUM - 1, 0, 0, "rd_last");
        applyStimulus(0, 0, 0, 1, WORD_NUM, 0, 0, "rd_oor350");
        checkOutput("rd_oor350_csb", 32'(bus.sram_csb), 32'(1));
        applyStimulus(0, 0, 0, 1, 400, 0, 0, "rd_oor400");
        checkOutput("rd_oor400_csb", 32'(bus.sram_csb), 32'(1));
        applyStimulus(1, 400, 1, 0, 0, 0, 0, "wr_oor400");
        checkOutput("wr_oor400_wsb", 32'(bus.sram_wsb), 32'(1));
        checkOutput("wr_oor400_csb", 32'(bus.sram_csb), 32'(1));
        applyStimulus(1, 30, 1, 1, 400, 0, 0, "mix_oor");
        checkOutput("mix_oor_csb", 32'(bus.sram_csb), 32'(0));
        applyStimulus(0, 0, 0, 1, 30, 0, 0, "rd30");
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, "idle");

        checkOutput("sb_drain", 32'(sbQ.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
